// File: rtl/clock_pkg.sv
// clock_pkg: shared state type, BCD limits and wrap-around increment helpers for clock setting
package clock_pkg;
  typedef enum logic [1:0] {RUN, SET_H, SET_M, COMMIT} set_state_t;
  localparam logic [1:0] HOUR_MAX_MSD      = 2'd2;
  localparam logic [3:0] HOUR_MAX_LSD_AT_2 = 4'd3;
  localparam logic [2:0] MIN_MAX_MSD       = 3'd5;
  localparam logic [3:0] BCD_MAX           = 4'd9;
  typedef struct packed {
    logic [1:0] msd;
    logic [3:0] lsd;
  } hour_t;
  typedef struct packed {
    logic [2:0] msd;
    logic [3:0] lsd;
  } min_t;
  function automatic hour_t hour_inc(input hour_t h);
    return (h.msd == HOUR_MAX_MSD && h.lsd == HOUR_MAX_LSD_AT_2) ? 6'd0 :
           (h.lsd == BCD_MAX) ? {h.msd + 2'd1, 4'd0} : {h.msd, h.lsd + 4'd1};
  endfunction
  function automatic min_t min_inc(input min_t m);
    return (m.lsd != BCD_MAX) ? {m.msd, m.lsd + 4'd1} :
           (m.msd == MIN_MAX_MSD) ? 7'd0 : {m.msd + 3'd1, 4'd0};
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-level debounce and one-cycle press pulse
//   clock, reset : system clock, synchronous active-high reset
//   btn          : raw asynchronous button level
//   evt          : one-cycle pulse on the debounced 0->1 edge
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic evt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, evt_q, evt_d, done;
  always_comb begin
    sync_d  = {sync_q[0], btn};
    done    = (sync_q[1] != level_q) && (cnt_q == LAST);
    cnt_d   = (sync_q[1] == level_q || done) ? '0 : cnt_q + 1'b1;
    level_d = done ? sync_q[1] : level_q;
    evt_d   = done & sync_q[1];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      evt_q   <= evt_d;
    end
  end
  assign evt = evt_q;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: two-button time-setting front end producing BCD load values for the clock counters
//   clock, reset         : system clock, synchronous active-high reset
//   btn_mode, btn_inc    : raw buttons (cycle fields / increment field)
//   cur_*                : live BCD time, copied in when editing starts
//   set_*                : BCD hour/minute to load
//   set_load             : one-cycle load strobe at commit
//   set_active           : counters hold while high
//   blink_h, blink_m     : blank the field being edited
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [1:0] cur_h_Msd,
  input  logic [3:0] cur_h_Lsd,
  input  logic [2:0] cur_m_Msd,
  input  logic [3:0] cur_m_Lsd,
  output logic [1:0] set_h_Msd,
  output logic [3:0] set_h_Lsd,
  output logic [2:0] set_m_Msd,
  output logic [3:0] set_m_Lsd,
  output logic       set_load,
  output logic       set_active,
  output logic       blink_h,
  output logic       blink_m
);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_CYCLES - 1);
  logic mode_evt, inc_evt;
  set_state_t state_q, state_d;
  hour_t hour_q, hour_d;
  min_t min_q, min_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic phase_q, phase_d, clr, wrap;
  logic load_q, load_d, active_q, active_d, bh_q, bh_d, bm_q, bm_d;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clock(clock), .reset(reset), .btn(btn_mode), .evt(mode_evt)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clock(clock), .reset(reset), .btn(btn_inc), .evt(inc_evt)
  );
  // mode is tested first in each edit state so a coincident increment is dropped
  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    case (state_q)
      RUN: if (mode_evt) begin
        state_d = SET_H;
        hour_d  = {cur_h_Msd, cur_h_Lsd};
        min_d   = {cur_m_Msd, cur_m_Lsd};
      end
      SET_H: if (mode_evt) state_d = SET_M;
        else if (inc_evt) hour_d = hour_inc(hour_q);
      SET_M: if (mode_evt) state_d = COMMIT;
        else if (inc_evt) min_d = min_inc(min_q);
      default: state_d = RUN;
    endcase
    // any state change or increment restarts the blink with the field visible
    clr      = state_d != state_q || inc_evt || !(state_q inside {SET_H, SET_M});
    wrap     = bcnt_q == BLAST;
    bcnt_d   = (clr || wrap) ? '0 : bcnt_q + 1'b1;
    phase_d  = clr ? 1'b0 : phase_q ^ wrap;
    active_d = state_d != RUN;
    load_d   = state_d == COMMIT;
    bh_d     = state_d == SET_H && phase_d;
    bm_d     = state_d == SET_M && phase_d;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      hour_q   <= '0;
      min_q    <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
      load_q   <= 1'b0;
      active_q <= 1'b0;
      bh_q     <= 1'b0;
      bm_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      load_q   <= load_d;
      active_q <= active_d;
      bh_q     <= bh_d;
      bm_q     <= bm_d;
    end
  end
  assign set_h_Msd  = hour_q.msd;
  assign set_h_Lsd  = hour_q.lsd;
  assign set_m_Msd  = min_q.msd;
  assign set_m_Lsd  = min_q.lsd;
  assign set_load   = load_q;
  assign set_active = active_q;
  assign blink_h    = bh_q;
  assign blink_m    = bm_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench for clock_set_ctrl with short debounce and blink periods
module tb_clock_set_ctrl;
  import clock_pkg::*;
  logic clock = 1'b0, reset = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [1:0] cur_h_Msd = '0;
  logic [3:0] cur_h_Lsd = '0;
  logic [2:0] cur_m_Msd = '0;
  logic [3:0] cur_m_Lsd = '0;
  logic [1:0] set_h_Msd;
  logic [3:0] set_h_Lsd;
  logic [2:0] set_m_Msd;
  logic [3:0] set_m_Lsd;
  logic set_load, set_active, blink_h, blink_m;
  int n_vec = 0, n_err = 0, load_count = 0, hr = 0, mn = 0, lat;
  logic prev_load = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] got_load;

  clock_set_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_h_Msd(cur_h_Msd), .cur_h_Lsd(cur_h_Lsd), .cur_m_Msd(cur_m_Msd), .cur_m_Lsd(cur_m_Lsd),
    .set_h_Msd(set_h_Msd), .set_h_Lsd(set_h_Lsd), .set_m_Msd(set_m_Msd), .set_m_Lsd(set_m_Lsd),
    .set_load(set_load), .set_active(set_active), .blink_h(blink_h), .blink_m(blink_m)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bcd(input int v);
    return 32'((v / 10) * 16 + v % 10);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input bit mode);
    if (mode) btn_mode = 1'b1; else btn_inc = 1'b1;
    cycles(12);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cycles(12);
  endtask

  task automatic check_time(input string tag);
    check({tag, "_hour"}, 32'({set_h_Msd, set_h_Lsd}), bcd(hr));
    check({tag, "_min"}, 32'({set_m_Msd, set_m_Lsd}), bcd(mn));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_vals"}, 32'({set_h_Msd, set_h_Lsd, set_m_Msd, set_m_Lsd}), 0);
    check({tag, "_flags"}, 32'({set_load, set_active, blink_h, blink_m}), 0);
    check({tag, "_state"}, 32'(dut.state_q), 32'(RUN));
  endtask

  task automatic start_edit(input int h, input int m);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    {cur_h_Msd, cur_h_Lsd} = 6'(bcd(h));
    {cur_m_Msd, cur_m_Lsd} = 7'(bcd(m));
    hr = h;
    mn = m;
    press(1'b1);
  endtask

  always @(negedge clock) begin
    if (set_load) begin
      load_count++;
      check("load_width", 32'(prev_load), 0);
      check("load_active", 32'(set_active), 1);
      check("load_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        got_load = {16'd0, 2'd0, set_h_Msd, set_h_Lsd, 1'b0, set_m_Msd, set_m_Lsd};
        check("load_value", got_load, exp_q.pop_front());
      end
    end
    prev_load = set_load;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cycles(3);
    reset = 1'b0;
    check_idle("reset");
    cycles(1000);
    check_idle("idle");
    check("idle_loads", 32'(load_count), 0);

    // 14:37 preload, entry latency and blink timing
    {cur_h_Msd, cur_h_Lsd, cur_m_Msd, cur_m_Lsd} = {2'd1, 4'd4, 3'd3, 4'd7};
    btn_mode = 1'b1;
    lat = 0;
    while (!set_active && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("entry_latency", 32'(lat), 7);
    hr = 14;
    mn = 37;
    check_time("preload");
    cycles(7);
    check("blink_h_early", 32'(blink_h), 0);
    cycles(1);
    check("blink_h_on", 32'(blink_h), 1);
    cycles(7);
    check("blink_h_hold", 32'(blink_h), 1);
    check("blink_m_off", 32'(blink_m), 0);
    cycles(1);
    check("blink_h_off", 32'(blink_h), 0);
    btn_mode = 1'b0;
    cycles(12);

    // hour 22 -> 23 -> 00 -> 01, minutes 58 -> 59 -> 00 -> 01, commit 01:01
    start_edit(22, 58);
    check_time("start22");
    check("in_set_h", 32'(dut.state_q), 32'(SET_H));
    for (int i = 0; i < 3; i++) begin
      press(1'b0);
      hr = (hr + 1) % 24;
      check_time("hour_inc");
    end
    press(1'b1);
    check("in_set_m", 32'(dut.state_q), 32'(SET_M));
    for (int i = 0; i < 3; i++) begin
      press(1'b0);
      mn = (mn + 1) % 60;
      check_time("min_inc");
    end
    exp_q.push_back((bcd(hr) << 8) | bcd(mn));
    press(1'b1);
    check("commit_loads", 32'(load_count), 1);
    check("commit_inactive", 32'(set_active), 0);
    check_time("commit_hold");

    // bounce on increment gives one step, long hold gives no repeat
    start_edit(4, 40);
    for (int i = 0; i < 10; i++) begin
      btn_inc = (i % 2 == 0);
      cycles(2);
    end
    btn_inc = 1'b1;
    cycles(200);
    hr = 5;
    check_time("bounce");
    btn_inc = 1'b0;
    cycles(12);

    // coincident mode and increment: mode wins
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    cycles(12);
    check("coincide_state", 32'(dut.state_q), 32'(SET_M));
    check_time("coincide");
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cycles(12);
    for (int i = 0; i < 5; i++) press(1'b0);
    mn = 45;
    check_time("min45");

    // reset while editing abandons the edit
    reset = 1'b1;
    cycles(1);
    check_idle("edit_reset");
    reset = 1'b0;
    cycles(50);
    check("total_loads", 32'(load_count), 1);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
